// File: rtl/hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline (master) and hazard_ctrl (slave).
// ID/EX hazard sources flow in; stall/flush controls and status flow out.
interface hazard_ctrl_if;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_use_rs1;
  logic        id_use_rs2;
  logic [4:0]  ex_rd;
  logic        ex_regs_write;
  logic        ex_mem2reg;
  logic        ex_br_taken;
  logic        ex_md_start;
  logic        pc_stall;
  logic        if_id_stall;
  logic        id_ex_stall;
  logic        if_id_flush;
  logic        id_ex_flush;
  logic        ex_me_flush;
  logic        md_busy;
  logic [1:0]  state;
  logic [31:0] stall_cnt;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_regs_write,
           ex_mem2reg, ex_br_taken, ex_md_start,
    input  pc_stall, if_id_stall, id_ex_stall, if_id_flush, id_ex_flush,
           ex_me_flush, md_busy, state, stall_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_regs_write,
           ex_mem2reg, ex_br_taken, ex_md_start,
    output pc_stall, if_id_stall, id_ex_stall, if_id_flush, id_ex_flush,
           ex_me_flush, md_busy, state, stall_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: branch flush, load-use bubble and multi-cycle
// mul/div hold, with a saturating count of PC-stall cycles.
module hazard_ctrl #(
  parameter int unsigned MD_LAT = 4
) (
  input  logic        clk,
  input  logic        rst,
  hazard_ctrl_if.slave hz
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LD_STALL = 2'd1,
    MD_BUSY  = 2'd2
  } state_e;

  localparam logic [3:0] MD_INIT = 4'(MD_LAT - 1);

  state_e      state_q, state_d;
  logic [3:0]  md_cnt_q, md_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  logic load_use;
  logic pc_stall, if_id_stall, id_ex_stall;
  logic if_id_flush, id_ex_flush, ex_me_flush;
  logic md_busy;

  assign load_use = hz.ex_mem2reg & hz.ex_regs_write & (hz.ex_rd != 5'd0) &
                    ((hz.id_use_rs1 & (hz.id_rs1 == hz.ex_rd)) |
                     (hz.id_use_rs2 & (hz.id_rs2 == hz.ex_rd)));

  always_comb begin
    state_d     = RUN;
    md_cnt_d    = md_cnt_q;
    pc_stall    = 1'b0;
    if_id_stall = 1'b0;
    id_ex_stall = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    ex_me_flush = 1'b0;
    unique case (state_q)
      RUN, LD_STALL: begin
        if (hz.ex_br_taken) begin
          // a redirect squashes whatever is behind it, so load-use is moot
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          state_d     = RUN;
        end else if (hz.ex_md_start) begin
          pc_stall    = 1'b1;
          if_id_stall = 1'b1;
          id_ex_stall = 1'b1;
          ex_me_flush = 1'b1;
          state_d     = MD_BUSY;
          md_cnt_d    = MD_INIT;
        end else if (load_use) begin
          pc_stall    = 1'b1;
          if_id_stall = 1'b1;
          id_ex_flush = 1'b1;
          state_d     = LD_STALL;
        end
      end
      MD_BUSY: begin
        if (md_cnt_q > 4'd1) begin
          pc_stall    = 1'b1;
          if_id_stall = 1'b1;
          id_ex_stall = 1'b1;
          ex_me_flush = 1'b1;
          state_d     = MD_BUSY;
          md_cnt_d    = md_cnt_q - 4'd1;
        end else begin
          // final EX cycle: result moves on to EX/ME
          state_d  = RUN;
          md_cnt_d = 4'd0;
        end
      end
      default: begin
        state_d  = RUN;
        md_cnt_d = 4'd0;
      end
    endcase
    if (rst) begin
      pc_stall    = 1'b0;
      if_id_stall = 1'b0;
      id_ex_stall = 1'b0;
      if_id_flush = 1'b0;
      id_ex_flush = 1'b0;
      ex_me_flush = 1'b0;
    end
  end

  assign md_busy     = (state_q == MD_BUSY) & ~rst;
  assign stall_cnt_d = (pc_stall && (stall_cnt_q != 32'hFFFF_FFFF)) ?
                       stall_cnt_q + 32'd1 : stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      md_cnt_q    <= 4'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      md_cnt_q    <= md_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign hz.pc_stall    = pc_stall;
  assign hz.if_id_stall = if_id_stall;
  assign hz.id_ex_stall = id_ex_stall;
  assign hz.if_id_flush = if_id_flush;
  assign hz.id_ex_flush = id_ex_flush;
  assign hz.ex_me_flush = ex_me_flush;
  assign hz.md_busy     = md_busy;
  assign hz.state       = state_q;
  assign hz.stall_cnt   = stall_cnt_q;

endmodule
